// File: rtl/bfly_stage_pipe_if.sv
// bfly_stage_pipe_if
//   Stream bundle for the first-stage butterfly block.
//   Input side : i_valid/i_ready handshake, i_enable, i_size, i_data (MAX_N lanes of IW bits).
//   Output side: o_valid/o_ready handshake, o_size, o_data (MAX_N lanes of IW+1 bits).
//   slave  modport : the butterfly block's view.
//   master modport : the environment's view (row fetch upstream + downstream consumer).
interface bfly_stage_pipe_if #(
  parameter int IW    = 18,
  parameter int MAX_N = 32
);
  logic                     i_valid;
  logic                     i_ready;
  logic                     i_enable;
  logic [1:0]               i_size;
  logic [MAX_N*IW-1:0]      i_data;
  logic                     o_valid;
  logic                     o_ready;
  logic [1:0]               o_size;
  logic [MAX_N*(IW+1)-1:0]  o_data;

  modport slave (
    input  i_valid, i_enable, i_size, i_data, o_ready,
    output i_ready, o_valid, o_size, o_data
  );

  modport master (
    output i_valid, i_enable, i_size, i_data, o_ready,
    input  i_ready, o_valid, o_size, o_data
  );
endinterface

// File: rtl/bfly_stage_pipe.sv
// bfly_stage_pipe
//   Registered first-stage even/odd butterfly. Each accepted vector of MAX_N
//   signed IW-bit lanes is split into segments of N = 4 << S points
//   (S = i_size clamped to log2(MAX_N)-2). With i_enable each segment produces
//   mirrored-pair sums in its low half and differences in its high half;
//   without it the lanes pass through sign-extended to IW+1 bits.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - bfly_stage_pipe_if slave modport (input and output handshakes)
//   Build option BFLY_SKID_EN: adds a one-entry skid buffer so i_ready comes
//   from a flop instead of combinationally from o_ready.
module bfly_stage_pipe #(
  parameter int IW    = 18,
  parameter int MAX_N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  bfly_stage_pipe_if.slave  bus
);

  localparam int OW   = IW + 1;
  localparam int SMAX = $clog2(MAX_N) - 2;

  function automatic logic signed [OW-1:0] sext(input logic [IW-1:0] x);
    return {x[IW-1], x};
  endfunction

  logic signed [OW-1:0]  lane_in [MAX_N];
  logic signed [OW-1:0]  bf      [4][MAX_N];
  logic [1:0]            size_p0;
  logic [MAX_N*OW-1:0]   data_p0;
  logic                  accept;
  logic                  in_ready;

  logic                  vld_p1;
  logic [1:0]            size_p1;
  logic [MAX_N*OW-1:0]   data_p1;

  // ---- stage p0: combinational butterfly on the presented vector ----
  for (genvar k = 0; k < MAX_N; k++) begin : g_in
    assign lane_in[k] = sext(bus.i_data[k*IW +: IW]);
  end

  // Every segment size is built statically; the mirror index of each lane is
  // a constant, so the per-transfer size only drives a final lane mux.
  for (genvar s = 0; s < 4; s++) begin : g_size
    for (genvar k = 0; k < MAX_N; k++) begin : g_lane
      if ((4 << s) <= MAX_N) begin : g_bf
        localparam int N = 4 << s;
        localparam int P = k % N;
        localparam int M = k - P + N - 1 - P;
        if (P < N / 2) begin : g_sum
          assign bf[s][k] = lane_in[k] + lane_in[M];
        end else begin : g_dif
          assign bf[s][k] = lane_in[M] - lane_in[k];
        end
      end else begin : g_na
        // Unreachable size for this MAX_N (clamped away); tie off.
        assign bf[s][k] = lane_in[k];
      end
    end
  end

  assign size_p0 = (bus.i_size > 2'(SMAX)) ? 2'(SMAX) : bus.i_size;

  always_comb begin
    data_p0 = '0;
    for (int k = 0; k < MAX_N; k++) begin
      data_p0[k*OW +: OW] = bus.i_enable ? bf[size_p0][k] : lane_in[k];
    end
  end

  assign accept      = bus.i_valid && in_ready;
  assign bus.i_ready = in_ready;
  assign bus.o_valid = vld_p1;
  assign bus.o_size  = size_p1;
  assign bus.o_data  = data_p1;

`ifdef BFLY_SKID_EN
  // ---- stage p1: output register plus one-entry skid ----
  logic                  skid_vld_p1;
  logic [1:0]            skid_size_p1;
  logic [MAX_N*OW-1:0]   skid_data_p1;
  logic                  out_free;

  assign out_free = !vld_p1 || bus.o_ready;
  assign in_ready = !skid_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      size_p1     <= '0;
      data_p1     <= '0;
      skid_vld_p1 <= 1'b0;
    end else if (out_free) begin
      // The skid always holds the older vector, so it drains first.
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        size_p1     <= skid_size_p1;
        data_p1     <= skid_data_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        size_p1 <= size_p0;
        data_p1 <= data_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !out_free) begin
      skid_size_p1 <= size_p0;
      skid_data_p1 <= data_p0;
    end
  end
`else
  // ---- stage p1: single output register ----
  assign in_ready = !vld_p1 || bus.o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      size_p1 <= '0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      size_p1 <= size_p0;
      data_p1 <= data_p0;
    end else if (bus.o_ready) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

endmodule
